// File: rtl/pal_timing_pkg.sv
// PAL progressive (312-line) timing constants and line classification
// shared by the sync generator and its counter.
package pal_timing_pkg;

    localparam int unsigned HC_W = 9;
    localparam int unsigned VC_W = 9;

    localparam logic [HC_W-1:0] H_TOTAL   = 9'd480;
    localparam logic [VC_W-1:0] V_TOTAL   = 9'd312;
    localparam logic [HC_W-1:0] HSYNC_LEN = 9'd35;
    localparam logic [HC_W-1:0] EQ_LEN    = 9'd18;
    localparam logic [HC_W-1:0] BROAD_LEN = 9'd205;
    localparam logic [HC_W-1:0] HALF_LINE = 9'd240;
    localparam logic [HC_W-1:0] ACT_W     = 9'd352;
    localparam logic [VC_W-1:0] ACT_H     = 9'd256;

    typedef enum logic [1:0] {
        EQ,
        BROAD,
        NORMAL
    } line_t;

    // Lines 0..5 form the vertical sync block: 2 EQ, 2 BROAD, 2 EQ.
    function automatic line_t line_type(input logic [VC_W-1:0] v);
        line_t lt;
        case (v)
            9'd0, 9'd1, 9'd4, 9'd5: lt = EQ;
            9'd2, 9'd3:             lt = BROAD;
            default:                lt = NORMAL;
        endcase
        return lt;
    endfunction

endpackage

// File: rtl/pal_hv_counter.sv
// Horizontal/vertical position counter; held at the frame origin while
// disabled, with pulses flagging the start of each line and frame.
module pal_hv_counter
    import pal_timing_pkg::*;
(
    input  logic            clk7,
    input  logic            rst,
    input  logic            enable,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic            line_start,
    output logic            frame_start
);

    logic h_last;
    logic v_last;

    assign h_last      = (hc == H_TOTAL - 9'd1);
    assign v_last      = (vc == V_TOTAL - 9'd1);
    assign line_start  = enable && (hc == '0);
    assign frame_start = line_start && (vc == '0);

    always_ff @(posedge clk7 or posedge rst) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (!enable) begin
            hc <= '0;
            vc <= '0;
        end else if (h_last) begin
            hc <= '0;
            vc <= v_last ? '0 : vc + 9'd1;
        end else begin
            hc <= hc + 9'd1;
        end
    end

endmodule

// File: rtl/pal_sync_gen.sv
// PAL composite sync and active-window generator on the 7.5 MHz pixel clock;
// all outputs registered one cycle after the (hc, vc) they describe.
module pal_sync_gen
    import pal_timing_pkg::*;
#(
    parameter int unsigned H_ACT_START = 96,
    parameter int unsigned V_ACT_START = 40
) (
    input  logic       clk7,
    input  logic       rst,
    input  logic       clocks_ready,
    output logic       csync_n,
    output logic       active,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic       line_strobe,
    output logic       frame_strobe
);

    localparam logic [HC_W-1:0] H_LO = 9'(H_ACT_START);
    localparam logic [HC_W-1:0] H_HI = 9'(H_ACT_START) + ACT_W - 9'd1;
    localparam logic [VC_W-1:0] V_LO = 9'(V_ACT_START);
    localparam logic [VC_W-1:0] V_HI = 9'(V_ACT_START) + ACT_H - 9'd1;

    logic [1:0]      sync_q;
    logic            ready_s;
    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic            line_start;
    logic            frame_start;

    always_ff @(posedge clk7 or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], clocks_ready};
        end
    end

    assign ready_s = sync_q[1];

    pal_hv_counter u_counter (
        .clk7        (clk7),
        .rst         (rst),
        .enable      (ready_s),
        .hc          (hc),
        .vc          (vc),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    line_t           lt;
    logic            sync_low;
    logic            in_h;
    logic            in_v;
    logic [HC_W-1:0] dx;
    logic [VC_W-1:0] dy;

    always_comb begin
        lt       = line_type(vc);
        sync_low = 1'b0;
        case (lt)
            EQ:      sync_low = (hc < EQ_LEN) ||
                                (hc >= HALF_LINE && hc < HALF_LINE + EQ_LEN);
            BROAD:   sync_low = (hc < BROAD_LEN) ||
                                (hc >= HALF_LINE && hc < HALF_LINE + BROAD_LEN);
            default: sync_low = (hc < HSYNC_LEN);
        endcase
        in_h = (hc >= H_LO) && (hc <= H_HI);
        in_v = (vc >= V_LO) && (vc <= V_HI);
        dx   = hc - H_LO;
        dy   = vc - V_LO;
    end

    // Gated on ready_s so a lost lock never lets a decode of the forced
    // origin (an EQ pulse and strobes) reach the pins.
    always_ff @(posedge clk7 or posedge rst) begin
        if (rst) begin
            csync_n      <= 1'b1;
            active       <= 1'b0;
            x            <= '0;
            y            <= '0;
            line_strobe  <= 1'b0;
            frame_strobe <= 1'b0;
        end else if (!ready_s) begin
            csync_n      <= 1'b1;
            active       <= 1'b0;
            x            <= '0;
            y            <= '0;
            line_strobe  <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            csync_n      <= !sync_low;
            active       <= in_h && in_v;
            x            <= (in_h && in_v) ? dx : '0;
            y            <= in_v ? dy[7:0] : '0;
            line_strobe  <= line_start;
            frame_strobe <= frame_start;
        end
    end

endmodule

// File: tb/tb_pal_sync_gen.sv
// Directed bench for pal_sync_gen: reset/lock start-up, full-frame timing,
// vertical sync pulse train, active window, lock loss and async reset.
module tb_pal_sync_gen;

    logic       clk7 = 1'b0;
    logic       rst;
    logic       clocks_ready;
    logic       csync_n;
    logic       active;
    logic [8:0] x;
    logic [7:0] y;
    logic       line_strobe;
    logic       frame_strobe;

    pal_sync_gen #(
        .H_ACT_START (96),
        .V_ACT_START (40)
    ) dut (
        .clk7         (clk7),
        .rst          (rst),
        .clocks_ready (clocks_ready),
        .csync_n      (csync_n),
        .active       (active),
        .x            (x),
        .y            (y),
        .line_strobe  (line_strobe),
        .frame_strobe (frame_strobe)
    );

    always #5 clk7 = ~clk7;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycles (sampled on falling edges) until frame_strobe, -1 if none.
    task automatic wait_frame(input int limit, output int cyc);
        bit found = 0;
        cyc = -1;
        for (int i = 1; i <= limit && !found; i++) begin
            @(negedge clk7);
            if (frame_strobe) begin
                cyc   = i;
                found = 1;
            end
        end
    endtask

    localparam int EXP_W [12] = '{18, 18, 18, 18, 205, 205, 205, 205, 18, 18, 18, 18};

    int c;
    int period;
    int fall_pos [12];
    int width    [12];
    int nf, nw, start;
    int low10, fall10;
    int ls, ls_bad;
    int act_cnt, first_act, last_act;
    int fx, fy, lx, ly, blank_x, blank_y;
    int lat, strobes;
    logic prev_cs, cs;

    initial begin
        rst          = 1'b1;
        clocks_ready = 1'b1;
        repeat (3) @(negedge clk7);
        check("rst_csync_n", csync_n, 1);
        check("rst_active", active, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_line_strobe", line_strobe, 0);
        check("rst_frame_strobe", frame_strobe, 0);

        rst = 1'b0;
        wait_frame(10, c);
        check("first_frame_latency", c, 3);
        check("first_line_strobe", line_strobe, 1);

        // Sample n of the frame reflects hc = n % 480, vc = n / 480.
        nf = 0; nw = 0; start = 0; low10 = 0; fall10 = 0;
        ls = 0; ls_bad = 0; act_cnt = 0; first_act = -1; last_act = -1;
        fx = -1; fy = -1; lx = -1; ly = -1; blank_x = -1; blank_y = -1;
        period = -1;
        prev_cs = 1'b1;
        for (int n = 0; n <= 150000; n++) begin
            if (n > 0) begin
                @(negedge clk7);
                if (frame_strobe) begin
                    period = n;
                    break;
                end
            end
            cs = csync_n;
            if (n < 2880) begin
                if (prev_cs && !cs) begin
                    if (nf < 12) fall_pos[nf] = n;
                    start = n;
                    nf++;
                end
                if (!prev_cs && cs) begin
                    if (nw < 12) width[nw] = n - start;
                    nw++;
                end
            end
            if (n >= 4800 && n < 5280) begin
                if (!cs) low10++;
                if (prev_cs && !cs) fall10++;
            end
            prev_cs = cs;
            if (line_strobe) begin
                ls++;
                if (n % 480 != 0) ls_bad++;
            end
            if (active) begin
                if (act_cnt == 0) begin
                    first_act = n; fx = int'(x); fy = int'(y);
                end
                act_cnt++;
                last_act = n; lx = int'(x); ly = int'(y);
            end
            if (n == 50 * 480 + 10) begin
                blank_x = int'(x); blank_y = int'(y);
            end
        end

        check("frame_period", period, 149760);
        check("vsync_falls", nf, 12);
        check("vsync_widths", nw, 12);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("vsync_width[%0d]", k), width[k], EXP_W[k]);
            check($sformatf("vsync_fall[%0d]", k), fall_pos[k], k * 240);
        end
        check("line10_low", low10, 35);
        check("line10_falls", fall10, 1);
        check("line_strobes", ls, 312);
        check("line_strobe_misplaced", ls_bad, 0);
        check("first_active_cycle", first_act, 19296);
        check("first_active_x", fx, 0);
        check("first_active_y", fy, 0);
        check("last_active_cycle", last_act, 142047);
        check("last_active_x", lx, 351);
        check("last_active_y", ly, 255);
        check("active_count", act_cnt, 90112);
        check("hblank_x", blank_x, 0);
        check("hblank_y", blank_y, 10);

        // Second frame: run to vc=100, hc=200 and drop the PLL lock.
        repeat (48200) @(negedge clk7);
        check("pre_drop_active", active, 1);
        check("pre_drop_x", x, 104);
        check("pre_drop_y", y, 60);
        clocks_ready = 1'b0;
        lat = -1; strobes = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk7);
            if (lat < 0 && csync_n && !active && x == 0 && y == 0) lat = i;
            if (line_strobe || frame_strobe) strobes++;
        end
        check("drop_latency_le4", int'(lat > 0 && lat <= 4), 1);
        check("drop_strobes", strobes, 0);
        check("drop_csync_n", csync_n, 1);

        clocks_ready = 1'b1;
        wait_frame(10, c);
        check("relock_frame_latency", c, 3);

        // Into the first broad pulse (vc=2, hc=50), then async reset mid-cycle.
        repeat (1010) @(negedge clk7);
        check("broad_low", csync_n, 0);
        #2 rst = 1'b1;
        #1 check("async_rst_csync_n", csync_n, 1);
        check("async_rst_active", active, 0);
        #1 rst = 1'b0;
        wait_frame(10, c);
        check("post_rst_frame_latency", c, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
